// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the datapath control and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            zero_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign-corrected on completion.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus,
  output logic [1:0]   dbg_state
);

  // Handshake: start_i is taken on a rising edge only while busy_o is low; op
  // and operands are captured at that edge. busy_o stays high until the edge
  // that registers result_o, and done_o is high for exactly the next cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_res;
  logic              neg_rem;
  logic              special;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   result;
  logic              busy;
  logic              done;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              is_div, div0, ovf;
  logic [XLEN-1:0]   spec_val;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c, rem_c, fin_val;

  always_comb begin
    a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
               (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) ||
               (bus.op_i == 3'b110);
    a_neg    = a_signed & bus.a_i[XLEN-1];
    b_neg    = b_signed & bus.b_i[XLEN-1];
    a_mag    = a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
    b_mag    = b_neg ? (~bus.b_i + 1'b1) : bus.b_i;
    is_div   = bus.op_i[2];
    div0     = is_div && (bus.b_i == '0);
    ovf      = ((bus.op_i == 3'b100) || (bus.op_i == 3'b110)) &&
               (bus.a_i == MIN_NEG) && (bus.b_i == '1);
    // Divide-by-zero and signed overflow bypass the iteration entirely.
    if (div0) spec_val = bus.op_i[1] ? bus.a_i : '1;
    else      spec_val = bus.op_i[1] ? '0 : MIN_NEG;
  end

  // Multiply keeps {partial product, multiplier} in acc; divide keeps
  // {partial remainder, dividend/quotient}. The extra bit covers carry/borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  end

  always_comb begin
    prod_c = neg_res ? (~acc + 1'b1) : acc;
    quo_c  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_c  = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    if (special) begin
      fin_val = acc[XLEN-1:0];
    end else begin
      case (op_q)
        3'b000:                 fin_val = prod_c[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fin_val = prod_c[2*XLEN-1:XLEN];
        3'b100, 3'b101:         fin_val = quo_c;
        default:                fin_val = rem_c;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      special <= 1'b0;
      acc     <= '0;
      opnd    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            op_q    <= bus.op_i;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            busy    <= 1'b1;
            cnt     <= CW'(XLEN-1);
            if (div0 || ovf) begin
              special <= 1'b1;
              acc     <= {{XLEN{1'b0}}, spec_val};
              opnd    <= '0;
              state   <= FINISH;
            end else begin
              special <= 1'b0;
              acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              opnd    <= is_div ? b_mag : a_mag;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            if (div_diff[XLEN]) acc <= {acc[2*XLEN-2:0], 1'b0};
            else                acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          end else begin
            acc <= acc[0] ? {mul_sum, acc[XLEN-1:1]}
                          : {1'b0, acc[2*XLEN-1:1]};
          end
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          result <= fin_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;
  assign bus.zero_o   = (result == '0);
  assign dbg_state    = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic
// reference model; results are checked by a queue-based scoreboard.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op[2] && b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    bus.op_i = 3'($urandom);
    bus.a_i  = $urandom;
    bus.b_i  = $urandom;
  endtask

  // Called while idle, #1 after a rising edge. Returns #1 after the done edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, input int abort_at);
    int cycles;
    int lat;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    exp_q.push_back(ref_model(op, a, b));
    lat = is_special(op, a, b) ? 1 : XLEN + 1;
    @(posedge clk); #1;
    check("busy_after_start", 64'(bus.busy_o), 64'd1);
    check("done_low_after_start", 64'(bus.done_o), 64'd0);
    if (!hold) bus.start_i = 1'b0;
    scramble();
    cycles = 0;
    while (!bus.done_o && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (abort_at != 0 && cycles == abort_at) begin
        #2 rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_result", 64'(bus.result_o), 64'd0);
        check("rst_zero", 64'(bus.zero_o), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_no_done", 64'(bus.done_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (hold) scramble();
    end
    bus.start_i = 1'b0;
    check("latency", 64'(cycles), 64'(lat));
    check("busy_at_done", 64'(bus.busy_o), 64'd0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done_o), 64'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", 64'(bus.result_o), 64'(e));
        check("zero_flag", 64'(bus.zero_o), 64'(e == 0));
      end
    end
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir_vecs[] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD},
    '{3'd1, 32'h8000_0000,  32'h8000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd0, 32'd0,          32'd5},
    '{3'd4, 32'hFFFF_FFF9,  32'd2},
    '{3'd6, 32'hFFFF_FFF9,  32'd2},
    '{3'd5, 32'd100,        32'd7},
    '{3'd7, 32'd100,        32'd7},
    '{3'd5, 32'd5,          32'd0},
    '{3'd6, 32'd5,          32'd0},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF}
  };

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    #12;
    check("reset_busy", 64'(bus.busy_o), 64'd0);
    check("reset_done", 64'(bus.done_o), 64'd0);
    check("reset_result", 64'(bus.result_o), 64'd0);
    check("reset_zero", 64'(bus.zero_o), 64'd1);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases issued back-to-back: each start lands in the done cycle.
    foreach (dir_vecs[i]) issue(dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b, 1'b0, 0);

    // Start held high with operands changing mid-flight.
    issue(3'd0, 32'd12345, 32'd678, 1'b1, 0);
    @(posedge clk); #1;
    check("held_start_single", 64'(bus.busy_o), 64'd0);

    // Reset at step 10 of a DIV, then a normal operation afterwards.
    issue(3'd4, 32'd1000, 32'd7, 1'b0, 10);
    issue(3'd4, 32'hFFFF_FC18, 32'd7, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 1'b0, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    repeat (3) @(posedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the RV32M operations, parametrised in data width. It sits beside the single-cycle ALU in the multicycle datapath. The control FSM holds the core in its execute state while `busy_o` is high. Operands are latched at start, processed one bit per cycle, sign-corrected, and returned in a held result register with a one-cycle completion pulse.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start_i`, input, 1: request; accepted only when `busy_o` = 0.
- `op_i`, input, 3: RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a_i`, input, XLEN: rs1 operand (multiplicand / dividend).
- `b_i`, input, XLEN: rs2 operand (multiplier / divisor).
- `busy_o`, output, 1: high while an operation is in flight.
- `done_o`, output, 1: one-cycle pulse when `result_o` has been updated.
- `result_o`, output, XLEN: last result; held until the next completion.
- `zero_o`, output, 1: `result_o` == 0; combinational from `result_o`.

## Operation
- FSM states: IDLE, CALC, FINISH. Reset state is IDLE.
- IDLE, on `start_i`=1:
  - Latch op and operand signs.
  - Latch magnitudes. A and B are signed for MULH/DIV/REM, A only for MULHSU, and unsigned otherwise.
  - Load the step counter with XLEN-1. Go to CALC.
  - Exception: special cases go directly to FINISH.
- CALC, one step per cycle, XLEN steps:
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract, producing the quotient and an XLEN-bit remainder.
  - Go to FINISH when the counter reaches 0.
- FINISH:
  - Apply sign correction. Negate the product if operand signs differ; negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL gives the low half; MULH, MULHSU and MULHU give the high half; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register the result, pulse `done_o`, return to IDLE.
- Special cases (RISC-V defined, no trap):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the original `a_i`.
  - Signed overflow (DIV/REM with a = 2^(XLEN-1), b = -1): DIV gives 2^(XLEN-1); REM gives 0.
- Operands and op are captured at acceptance; later changes on `a_i`, `b_i` and `op_i` have no effect.
- `start_i` while `busy_o`=1 is ignored; it is neither queued nor allowed to corrupt state.
- An undefined combination cannot occur, since all 8 op codes are valid.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, `zero_o`=1, internal registers cleared. Assertion during CALC aborts the operation with no `done_o`.
- Normal latency: start sampled at edge E0.
  - `busy_o` is high from E0.
  - CALC spans E1..E_XLEN.
  - FINISH completes at E_(XLEN+1): `result_o` is valid, `done_o`=1 and `busy_o`=0 for the cycle after that edge.
  - Total: XLEN+1 edges.
- Special-case latency: FINISH completes at E1, so `done_o` goes high one cycle after acceptance.
- `done_o` lasts exactly one cycle. `result_o` is stable from the `done_o` cycle until the next completion.
- Back-to-back: `start_i` may be high during the `done_o` cycle; it is accepted at that edge.
- `busy_o` is registered, with no combinational path from `start_i`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32 → `result_o`=0xFFFFFFEB. `done_o` on edge 33 after the start edge; `busy_o` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 0×5 → 0 with `zero_o`=1.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done_o` one cycle after start. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Start held high throughout a MUL, with operands changed mid-flight → a single result from the latched operands. Restart in the `done_o` cycle → accepted, with correct second result.
- `rst_n` pulsed low at step 10 of a DIV → outputs immediately reset, no `done_o`. A new start after release completes normally.
